// File: rtl/btoex3_conv_df.sv
// BCD digit to Excess-3 converter with a registered output stage and a
// saturating count of successful conversions.
module btoex3_conv_df #(
    parameter logic [3:0] ERR_CODE = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] bin,
    output logic       out_valid,
    output logic [3:0] excess3,
    output logic       err,
    output logic [7:0] conv_count
);

    // Count increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        logic [7:0] r;
        r = (c == 8'hFF) ? c : c + 8'd1;
        return r;
    endfunction

    // Stage 0: gate-level Excess-3 core on the raw input.
    logic       digit_ok_p0;
    logic [3:0] e_p0;
    logic [3:0] e_sel_p0;

    // Digits 10..15 are exactly the codes with B3 set and either B2 or B1 set.
    assign digit_ok_p0 = ~(bin[3] & (bin[2] | bin[1]));
    assign e_p0[3]     = bin[3] | (bin[2] & (bin[1] | bin[0]));
    assign e_p0[2]     = bin[2] ^ (bin[1] | bin[0]);
    assign e_p0[1]     = ~(bin[1] ^ bin[0]);
    assign e_p0[0]     = ~bin[0];
    assign e_sel_p0    = digit_ok_p0 ? e_p0 : ERR_CODE;

    // Stage 1: registered result, flags and conversion count.
    logic       vld_p1;
    logic [3:0] excess3_p1;
    logic       err_p1;
    logic [7:0] cnt_p1;

    // Capture a result only on in_valid; data holds its last value otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            excess3_p1 <= 4'b0000;
            err_p1     <= 1'b0;
            cnt_p1     <= 8'h00;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                excess3_p1 <= e_sel_p0;
                err_p1     <= ~digit_ok_p0;
                if (digit_ok_p0) begin
                    cnt_p1 <= sat_inc(cnt_p1);
                end
            end
        end
    end

    assign out_valid  = vld_p1;
    assign excess3    = excess3_p1;
    assign err        = err_p1;
    assign conv_count = cnt_p1;

endmodule

// File: tb/tb_btoex3_conv_df.sv
// Scoreboard bench for btoex3_conv_df: directed sweeps, invalid digits,
// gaps, reset priority, counter saturation and an exhaustive input sweep.
module tb_btoex3_conv_df;

    localparam logic [3:0] ERR_CODE = 4'b0000;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] bin;
    logic       out_valid;
    logic [3:0] excess3;
    logic       err;
    logic [7:0] conv_count;

    int n_vec;
    int n_err;

    logic [4:0] sb_q[$];
    logic [7:0] cnt_m;

    btoex3_conv_df #(.ERR_CODE(ERR_CODE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .bin       (bin),
        .out_valid (out_valid),
        .excess3   (excess3),
        .err       (err),
        .conv_count(conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference from the published gate equations, ERR_CODE outside 0..9.
    function automatic logic [4:0] model(input logic [3:0] b);
        logic [3:0] e;
        if (b > 4'd9) return {ERR_CODE, 1'b1};
        e[3] = b[3] | (b[2] & (b[1] | b[0]));
        e[2] = b[2] ^ (b[1] | b[0]);
        e[1] = ~(b[1] ^ b[0]);
        e[0] = ~b[0];
        return {e, 1'b0};
    endfunction

    // Apply one cycle of stimulus and check the control outputs after the edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] b);
        rst      = r;
        in_valid = v;
        bin      = b;
        if (v && !r) sb_q.push_back(model(b));
        @(posedge clk);
        if (r) cnt_m = 8'h00;
        else if (v && b <= 4'd9 && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, v & ~r});
        chk("conv_count", {24'd0, conv_count}, {24'd0, cnt_m});
    endtask

    // Pop and compare every result the DUT presents.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                logic [4:0] e;
                e = sb_q.pop_front();
                chk("result", {27'd0, excess3, err}, {27'd0, e});
            end
        end
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        cnt_m    = 8'h00;
        rst      = 1'b1;
        in_valid = 1'b0;
        bin      = 4'd0;

        // Reset for two cycles
        drive(1'b1, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 4'd0);
        chk("rst_excess3", {28'd0, excess3}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Valid sweep 0..9
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 4'(i));
        chk("sweep_last", {28'd0, excess3}, 32'hC);
        chk("sweep_count", {24'd0, conv_count}, 32'd10);

        // Invalid digits
        for (int i = 10; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'(i));
            chk("inv_err", {31'd0, err}, 32'd1);
        end
        chk("inv_count", {24'd0, conv_count}, 32'd10);

        // Gap handling: 5, idle, 9
        drive(1'b0, 1'b1, 4'd5);
        chk("gap_first", {28'd0, excess3}, 32'h8);
        drive(1'b0, 1'b0, 4'd12);
        chk("gap_hold", {28'd0, excess3}, 32'h8);
        chk("gap_hold_err", {31'd0, err}, 32'd0);
        drive(1'b0, 1'b1, 4'd9);
        chk("gap_second", {28'd0, excess3}, 32'hC);

        // Reset priority mid-stream, then first post-reset conversion
        drive(1'b0, 1'b1, 4'd7);
        drive(1'b1, 1'b1, 4'd3);
        chk("rstpri_excess3", {28'd0, excess3}, 32'd0);
        chk("rstpri_err", {31'd0, err}, 32'd0);
        drive(1'b0, 1'b1, 4'd2);
        chk("post_rst", {28'd0, excess3}, 32'h5);

        // Saturation: 260 valid conversions from reset
        drive(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 260; i++) drive(1'b0, 1'b1, 4'($urandom_range(0, 9)));
        chk("sat_ff", {24'd0, conv_count}, 32'hFF);
        drive(1'b0, 1'b1, 4'd4);
        drive(1'b0, 1'b1, 4'd14);
        drive(1'b0, 1'b0, 4'd1);
        chk("sat_stay", {24'd0, conv_count}, 32'hFF);

        // Exhaustive: all 16 codes, with random idle cycles and don't-care bin
        drive(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'(i));
            if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
        end
        chk("exh_count", {24'd0, conv_count}, 32'd10);
        drive(1'b0, 1'b0, 4'd0);
        @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
